// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core/DMA data-memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int MAXB_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one DMA burst; a length of zero encodes the full 2^LW beats.
module burst_counter #(
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          areset,
   input  logic          clr,
   input  logic          en,
   input  logic [LW-1:0] len,
   output logic [LW-1:0] beat,
   output logic          last
);

   localparam logic [LW-1:0] ONE = LW'(1);

   logic [LW-1:0] beat_r;

   // Modulo-2^LW subtraction makes len=0 terminate at the all-ones beat.
   assign last = (beat_r == (len - ONE));
   assign beat = beat_r;

   // Beat register: restarts on a new grant and after the terminal beat.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         beat_r <= '0;
      end else if (clr) begin
         beat_r <= '0;
      end else if (en) begin
         beat_r <= last ? '0 : (beat_r + ONE);
      end else begin
         beat_r <= beat_r;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between a stalling core and a burst DMA.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int MAXB = MAXB_DEFAULT,
   parameter int LW   = $clog2(MAXB)
) (
   input  logic          clk,
   input  logic          areset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic [DW-1:0] c_rdata,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [LW-1:0] d_len,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_beat,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t    state_r, state_s;
   logic          prio_r, prio_s;
   logic [AW-1:0] base_r;
   logic          we_r;
   logic [LW-1:0] len_r;

   logic          gnt_s, beat_en_s, last_s, mem_we_s, d_beat_s, d_done_s;
   logic [LW-1:0] beat_s;
   logic [AW-1:0] offset_s;

   burst_counter #(.LW(LW)) u_cnt (
      .clk    (clk),
      .areset (areset),
      .clr    (gnt_s),
      .en     (beat_en_s),
      .len    (len_r),
      .beat   (beat_s),
      .last   (last_s)
   );

   assign beat_en_s = (state_r == BURST);
   assign offset_s  = {{(AW-LW-2){1'b0}}, beat_s, 2'b00};

   // Read data is simply steered to both requesters; strobes say who owns it.
   assign c_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // Reset forces every write enable and pulse low regardless of inputs.
   assign mem_we = mem_we_s & areset;
   assign d_gnt  = gnt_s & areset;
   assign d_beat = d_beat_s & areset;
   assign d_done = d_done_s & areset;

   // Arbitration state, priority bit and the burst descriptor captured at grant.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_r <= IDLE;
         prio_r  <= 1'b0;
         base_r  <= '0;
         we_r    <= 1'b0;
         len_r   <= '0;
      end else begin
         state_r <= state_s;
         prio_r  <= prio_s;
         if (gnt_s) begin
            base_r <= d_addr;
            we_r   <= d_we;
            len_r  <= d_len;
         end else begin
            base_r <= base_r;
            we_r   <= we_r;
            len_r  <= len_r;
         end
      end
   end

   // Next state and memory-port steering.
   always_comb begin
      state_s   = state_r;
      prio_s    = prio_r;
      gnt_s     = 1'b0;
      mem_we_s  = 1'b0;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      c_stall   = c_req;
      d_beat_s  = 1'b0;
      d_done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (d_req && (!c_req || prio_r)) begin
               gnt_s   = 1'b1;
               state_s = BURST;
            end else if (c_req) begin
               mem_we_s = c_we;
               c_stall  = 1'b0;
               // A DMA that lost this cycle wins the next contended one.
               prio_s   = d_req ? 1'b1 : prio_r;
            end else begin
               state_s = IDLE;
            end
         end
         BURST: begin
            mem_addr  = base_r + offset_s;
            mem_we_s  = we_r;
            mem_wdata = d_wdata;
            d_beat_s  = 1'b1;
            if (last_s) begin
               d_done_s = 1'b1;
               state_s  = IDLE;
               prio_s   = 1'b0;
            end else begin
               state_s = BURST;
            end
         end
         default: begin
            state_s = IDLE;
            prio_s  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural data memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        areset;
   logic        c_req, c_we;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic        c_stall;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_len;
   logic        d_gnt, d_beat, d_done;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:1023];
   int checks = 0;
   int errors = 0;

   mem_arbiter dut (
      .clk(clk), .areset(areset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_stall(c_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_beat(d_beat), .d_done(d_done), .d_rdata(d_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[11:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; d_req = 1'b1;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
      checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
      checks++; if (d_beat !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rst_pulses got beat=%b done=%b want 0", d_beat, d_done); end
      checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL rst_c_stall got %b want 0", c_stall); end
      c_req = 1'b0; d_req = 1'b0;
      next_cycle();
      areset = 1'b1;
   endtask

   task automatic test_core_only();
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hA5;
      @(negedge clk);
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL core_we got %b want 1", mem_we); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL core_addr got %h want 10", mem_addr); end
      checks++; if (mem_wdata !== 32'hA5) begin errors++; $display("FAIL core_wdata got %h want a5", mem_wdata); end
      checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL core_stall got %b want 0", c_stall); end
      next_cycle();
      c_we = 1'b0;
      @(negedge clk);
      checks++; if (c_rdata !== 32'hA5) begin errors++; $display("FAIL core_load got %h want a5", c_rdata); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL core_load_we got %b want 0", mem_we); end
      next_cycle();
      c_req = 1'b0; c_we = 1'b1; c_addr = 32'h44;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h44) begin errors++; $display("FAIL idle_port got we=%b addr=%h want we=0 addr=44", mem_we, mem_addr); end
      c_we = 1'b0;
      next_cycle();
   endtask

   task automatic test_dma_write();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_len = 4'd4;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || d_beat !== 1'b0) begin errors++; $display("FAIL dw_grant got gnt=%b we=%b beat=%b want 1 0 0", d_gnt, mem_we, d_beat); end
      next_cycle();
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'hDEAD0000; d_len = 4'd1;
      for (int i = 0; i < 4; i++) begin
         d_wdata = 32'hD0 + 32'(i);
         @(negedge clk);
         checks++; if (d_beat !== 1'b1 || mem_we !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL dw_beat%0d got beat=%b we=%b gnt=%b want 1 1 0", i, d_beat, mem_we, d_gnt); end
         checks++; if (mem_addr !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL dw_addr%0d got %h want %h", i, mem_addr, 32'h100 + 32'(4*i)); end
         checks++; if (d_done !== (i == 3)) begin errors++; $display("FAIL dw_done%0d got %b want %b", i, d_done, (i == 3)); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (d_beat !== 1'b0 || d_done !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL dw_after got beat=%b done=%b we=%b want 0", d_beat, d_done, mem_we); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem[64+i] !== 32'hD0 + 32'(i)) begin errors++; $display("FAIL dw_mem%0d got %h want %h", i, mem[64+i], 32'hD0 + 32'(i)); end
      end
      next_cycle();
   endtask

   task automatic test_contention();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_len = 4'd2;
      @(negedge clk);
      checks++; if (c_stall !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'h20) begin errors++; $display("FAIL ct_core_first got stall=%b gnt=%b addr=%h want 0 0 20", c_stall, d_gnt, mem_addr); end
      next_cycle();
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1 || c_stall !== 1'b1) begin errors++; $display("FAIL ct_grant got gnt=%b stall=%b want 1 1", d_gnt, c_stall); end
      next_cycle();
      @(negedge clk);
      checks++; if (d_beat !== 1'b1 || c_stall !== 1'b1 || mem_addr !== 32'h300 || d_done !== 1'b0) begin errors++; $display("FAIL ct_beat0 got beat=%b stall=%b addr=%h done=%b", d_beat, c_stall, mem_addr, d_done); end
      next_cycle();
      @(negedge clk);
      checks++; if (d_beat !== 1'b1 || c_stall !== 1'b1 || mem_addr !== 32'h304 || d_done !== 1'b1) begin errors++; $display("FAIL ct_beat1 got beat=%b stall=%b addr=%h done=%b", d_beat, c_stall, mem_addr, d_done); end
      next_cycle();
      @(negedge clk);
      checks++; if (c_stall !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'h20) begin errors++; $display("FAIL ct_core_after got stall=%b gnt=%b addr=%h want 0 0 20", c_stall, d_gnt, mem_addr); end
      next_cycle();
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1 || c_stall !== 1'b1) begin errors++; $display("FAIL ct_prio got gnt=%b stall=%b want 1 1", d_gnt, c_stall); end
      next_cycle();
      c_req = 1'b0; d_req = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_wrap();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFFFFFF8; d_len = 4'd0;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wr_grant got %b want 1", d_gnt); end
      next_cycle();
      d_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (d_beat !== 1'b1 || mem_addr !== 32'hFFFFFFF8 + 32'(4*i)) begin errors++; $display("FAIL wr_beat%0d got beat=%b addr=%h want %h", i, d_beat, mem_addr, 32'hFFFFFFF8 + 32'(4*i)); end
         checks++; if (d_done !== (i == 15)) begin errors++; $display("FAIL wr_done%0d got %b want %b", i, d_done, (i == 15)); end
         if (i == 2) begin
            checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wr_third got %h want 00000000", mem_addr); end
         end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (d_beat !== 1'b0) begin errors++; $display("FAIL wr_after got beat=%b want 0", d_beat); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      mem[258] = 32'h55;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_len = 4'd8; d_wdata = 32'hEE;
      next_cycle();
      d_req = 1'b0;
      next_cycle();
      next_cycle();
      areset = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0 || d_beat !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rm_async got we=%b beat=%b done=%b want 0", mem_we, d_beat, d_done); end
      next_cycle();
      checks++; if (mem[258] !== 32'h55) begin errors++; $display("FAIL rm_nowrite got %h want 55", mem[258]); end
      checks++; if (mem[256] !== 32'hEE || mem[257] !== 32'hEE) begin errors++; $display("FAIL rm_early got %h %h want ee ee", mem[256], mem[257]); end
      areset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (mem_we !== 1'b0 || d_beat !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rm_idle%0d got we=%b beat=%b done=%b want 0", i, mem_we, d_beat, d_done); end
         next_cycle();
      end
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      @(negedge clk);
      checks++; if (c_stall !== 1'b0 || mem_addr !== 32'h10 || c_rdata !== 32'hA5) begin errors++; $display("FAIL rm_core got stall=%b addr=%h rdata=%h want 0 10 a5", c_stall, mem_addr, c_rdata); end
      next_cycle();
      c_req = 1'b0;
   endtask

   task automatic test_dma_read();
      mem[128] = 32'h11; mem[129] = 32'h22;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_len = 4'd2; d_wdata = 32'hFF;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rd_grant got %b want 1", d_gnt); end
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      checks++; if (d_beat !== 1'b1 || d_rdata !== 32'h11 || mem_we !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL rd_beat0 got beat=%b data=%h we=%b done=%b want 1 11 0 0", d_beat, d_rdata, mem_we, d_done); end
      next_cycle();
      @(negedge clk);
      checks++; if (d_beat !== 1'b1 || d_rdata !== 32'h22 || mem_we !== 1'b0 || d_done !== 1'b1) begin errors++; $display("FAIL rd_beat1 got beat=%b data=%h we=%b done=%b want 1 22 0 1", d_beat, d_rdata, mem_we, d_done); end
      next_cycle();
      checks++; if (mem[128] !== 32'h11 || mem[129] !== 32'h22) begin errors++; $display("FAIL rd_intact got %h %h want 11 22", mem[128], mem[129]); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_len = 4'd0; d_wdata = 32'h0;
      areset = 1'b0;
      #1;
      test_reset();
      test_core_only();
      test_dma_write();
      test_contention();
      test_wrap();
      test_reset_mid();
      test_dma_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
